// File: rtl/seq_tx_pkg.sv
// Shared definitions for the serial pattern transmitter and the detector
// benches that consume its frames: state encoding and frame-length helpers.
package seq_tx_pkg;

    // Transmitter states; the unused encoding falls back to IDLE in the FSM.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_REP_W = 4;

    // A requested length of 0, or one longer than the pattern register,
    // means "send the whole register".
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned width);
        if (len == 0 || len > width)
            return width;
        return len;
    endfunction

    // A repeat count of 0 is treated as a single repetition.
    function automatic int unsigned clamp_reps(input int unsigned reps);
        return (reps == 0) ? 1 : reps;
    endfunction

    // Number of serial bits in one frame, for consumers that need to know
    // how long dout_valid will stay high.
    function automatic int unsigned frame_bits(input int unsigned len,
                                               input int unsigned reps,
                                               input int unsigned width);
        return clamp_len(len, width) * clamp_reps(reps);
    endfunction

endpackage

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: accepts a parallel pattern over a
// valid/ready port and shifts it out MSB-first, one bit per clock,
// optionally repeated back-to-back, followed by a one-cycle done pulse.
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned LEN_W = $clog2(WIDTH + 1),
    parameter int unsigned REP_W = DEF_REP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    input  logic [REP_W-1:0] load_reps,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    // Bit index only needs to address the pattern register.
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q;
    logic [WIDTH-1:0] data_q;
    logic [LEN_W-1:0] len_q;
    logic [IDX_W-1:0] idx_q;
    // Remaining repetitions including the current one; reaching zero means
    // every bit has been registered and the next edge raises done.
    logic [REP_W-1:0] reps_q;
    logic             dout_q;
    logic             dout_valid_q;
    logic             busy_q;
    logic             done_q;

    logic [LEN_W-1:0] len_d;
    logic [REP_W-1:0] reps_d;

    // Normalised length and repeat count of the request on the load port.
    always_comb begin
        len_d  = LEN_W'(clamp_len(32'(load_len), WIDTH));
        reps_d = REP_W'(clamp_reps(32'(load_reps)));
    end

    // Ready only when idle, and never while reset is being applied.
    assign load_ready = (state_q == ST_IDLE) && !rst;

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

    // Single-process FSM: load, shift/repeat bookkeeping and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            data_q       <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            reps_q       <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    dout_q       <= 1'b0;
                    dout_valid_q <= 1'b0;
                    done_q       <= 1'b0;
                    busy_q       <= 1'b0;
                    if (load_valid) begin
                        data_q  <= load_data;
                        len_q   <= len_d;
                        reps_q  <= reps_d;
                        idx_q   <= IDX_W'(len_d - 1'b1);
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (reps_q == '0) begin
                        // Last bit went out on the previous edge.
                        dout_q       <= 1'b0;
                        dout_valid_q <= 1'b0;
                        done_q       <= 1'b1;
                        state_q      <= ST_DONE;
                    end else begin
                        dout_q       <= data_q[idx_q];
                        dout_valid_q <= 1'b1;
                        if (idx_q != '0) begin
                            idx_q <= idx_q - 1'b1;
                        end else begin
                            // Reload for the next repetition with no gap cycle.
                            idx_q  <= IDX_W'(len_q - 1'b1);
                            reps_q <= reps_q - 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    dout_q       <= 1'b0;
                    dout_valid_q <= 1'b0;
                    done_q       <= 1'b0;
                    busy_q       <= 1'b0;
                    data_q       <= '0;
                    len_q        <= '0;
                    idx_q        <= '0;
                    reps_q       <= '0;
                    state_q      <= ST_IDLE;
                end

                default: begin
                    state_q      <= ST_IDLE;
                    data_q       <= '0;
                    len_q        <= '0;
                    idx_q        <= '0;
                    reps_q       <= '0;
                    dout_q       <= 1'b0;
                    dout_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed and randomized frames for seq_pattern_tx, compared cycle by cycle
// against an expected bit stream built from the pattern, length and repeats.
module tb_seq_pattern_tx;

    localparam int WIDTH = 8;
    localparam int LEN_W = 4;
    localparam int REP_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic [LEN_W-1:0] load_len;
    logic [REP_W-1:0] load_reps;
    logic             dout;
    logic             dout_valid;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;
    bit last_bits[$];

    seq_pattern_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_len   (load_len),
        .load_reps  (load_reps),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Send one frame and check every cycle until the block is idle again.
    // hold: keep load_valid high with the next request during the frame.
    // abort: assert rst after that many bits (0 = run to completion).
    task automatic run_frame(input logic [7:0] d, input int len, input int reps,
                             input bit hold, input logic [7:0] nd, input int nlen,
                             input int nreps, input int abort);
        int  eff_len;
        int  eff_reps;
        int  waitc;
        bit  exp_q[$];
        eff_len  = (len == 0 || len > WIDTH) ? WIDTH : len;
        eff_reps = (reps == 0) ? 1 : reps;
        for (int r = 0; r < eff_reps; r++)
            for (int i = eff_len - 1; i >= 0; i--)
                exp_q.push_back(d[i]);

        @(negedge clk);
        load_valid = 1'b1;
        load_data  = d;
        load_len   = LEN_W'(len);
        load_reps  = REP_W'(reps);
        waitc = 0;
        while (!load_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 50) begin
            chk("ready_timeout", 32'd0, 32'd1);
            load_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (hold) begin
            load_data = nd;
            load_len  = LEN_W'(nlen);
            load_reps = REP_W'(nreps);
        end else begin
            load_valid = 1'b0;
            load_data  = 8'($urandom);
            load_len   = LEN_W'($urandom);
            load_reps  = REP_W'($urandom);
        end

        last_bits.delete();
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bit%0d", i), 32'(dout), 32'(exp_q[i]));
            chk("dout_valid", 32'(dout_valid), 32'd1);
            chk("busy_shift", 32'(busy), 32'd1);
            chk("ready_shift", 32'(load_ready), 32'd0);
            chk("done_shift", 32'(done), 32'd0);
            last_bits.push_back(dout);
            if (abort != 0 && i + 1 == abort) begin
                @(negedge clk);
                rst = 1'b1;
                @(posedge clk);
                #1;
                chk("abort_dout", 32'(dout), 32'd0);
                chk("abort_valid", 32'(dout_valid), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                rst = 1'b0;
                #1;
                chk("abort_ready", 32'(load_ready), 32'd1);
                $display("frame data=%02h len=%0d reps=%0d aborted after %0d bits", d, len, reps, abort);
                return;
            end
        end

        @(posedge clk);
        #1;
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_dout", 32'(dout), 32'd0);
        chk("done_valid", 32'(dout_valid), 32'd0);
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_ready", 32'(load_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ready", 32'(load_ready), 32'd1);
        chk("idle_valid", 32'(dout_valid), 32'd0);
        $display("frame data=%02h len=%0d reps=%0d bits=%0d", d, len, reps, exp_q.size());
    endtask

    initial begin
        int hits;
        int p1;
        int p2;
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        load_len   = '0;
        load_reps  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(load_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(load_ready), 32'd1);

        // Single pattern 1001
        run_frame(8'h09, 4, 1, 1'b0, 8'h00, 0, 0, 0);
        // Repeated 1001 twice, no gap
        run_frame(8'h09, 4, 2, 1'b0, 8'h00, 0, 0, 0);

        // Loopback: overlapping 1001 detector sees two hits 3 cycles apart
        run_frame(8'h49, 7, 1, 1'b0, 8'h00, 0, 0, 0);
        hits = 0;
        p1 = 0;
        p2 = 0;
        for (int i = 3; i < last_bits.size(); i++) begin
            if (last_bits[i-3] && !last_bits[i-2] && !last_bits[i-1] && last_bits[i]) begin
                if (hits == 0) p1 = i;
                else if (hits == 1) p2 = i;
                hits++;
            end
        end
        chk("det_hits", 32'(hits), 32'd2);
        chk("det_gap", 32'(p2 - p1), 32'd3);

        // Clamp and defaults
        run_frame(8'hA5, 0, 0, 1'b0, 8'h00, 0, 0, 0);
        run_frame(8'hA5, 15, 1, 1'b0, 8'h00, 0, 0, 0);

        // Request held during a busy frame is only taken once idle
        run_frame(8'h3C, 5, 1, 1'b1, 8'hC3, 6, 2, 0);
        run_frame(8'hC3, 6, 2, 1'b0, 8'h00, 0, 0, 0);

        // Reset mid-frame, then immediate new load
        run_frame(8'hFF, 8, 1, 1'b0, 8'h00, 0, 0, 3);
        run_frame(8'h81, 8, 1, 1'b0, 8'h00, 0, 0, 0);

        // Randomized frames
        for (int n = 0; n < 20; n++) begin
            run_frame(8'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                      1'b0, 8'h00, 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
